// File: rtl/muxn_pkg.sv
// Shared definitions for the muxn_reg channel multiplexer: mode encodings and
// the clog2 helper used to size select/channel index fields.
package muxn_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Ceiling log2, with a floor of 1 so an index field is never zero-width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/muxn_rr_pick.sv
// Wrap-around first-valid search: returns the first set bit of the valid vector
// at or above the pointer, wrapping from N-1 back to 0.
module muxn_rr_pick
  import muxn_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          any
);

  // Scan offsets 0..N-1 from the pointer; the first hit wins.
  always_comb begin
    logic [SW-1:0] idx;
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = SW'((32'(ptr) + k) % N);
      if (!any && valid[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muxn_reg.sv
// N-channel registered multiplexer with fixed-select and round-robin modes.
// Optional output parity is enabled by defining MUXN_REG_PARITY_EN.
module muxn_reg
  import muxn_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned SW = clog2(N)
) (
  input  logic           inClk,
  input  logic           inRst,
  input  logic [N*W-1:0] inData,
  input  logic [N-1:0]   inValid,
  output logic [N-1:0]   outReady,
  input  logic           inMode,
  input  logic [SW-1:0]  inSel,
  input  logic           inReady,
  output logic           outValid,
  output logic [W-1:0]   outData,
  output logic [SW-1:0]  outChan
`ifdef MUXN_REG_PARITY_EN
  ,
  output logic           outPar
`endif
);

  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_chan_q;
  logic [SW-1:0] rr_ptr_q;

  logic          load;
  logic          sel_ok;
  logic          grant_valid;
  logic          transfer;
  logic [SW-1:0] grant;
  logic [SW-1:0] rr_grant;
  logic          rr_any;
  logic [SW-1:0] ptr_next;

  muxn_rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_rr_pick (
    .valid (inValid),
    .ptr   (rr_ptr_q),
    .grant (rr_grant),
    .any   (rr_any)
  );

  // Grant selection and the combinational accept strobe for the granted channel.
  always_comb begin
    load        = !out_valid_q || inReady;
    sel_ok      = (32'(inSel) < N);
    grant       = '0;
    grant_valid = 1'b0;
    if (inMode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_any;
    end else if (sel_ok) begin
      grant       = inSel;
      grant_valid = inValid[inSel];
    end
    transfer = !inRst && load && grant_valid;
    outReady = '0;
    if (transfer) outReady[grant] = 1'b1;
    ptr_next = (32'(grant) == N - 1) ? '0 : grant + SW'(1);
  end

  // Output register stage and round-robin pointer.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else if (load) begin
      // A load cycle with no grant empties the register but keeps stale data.
      out_valid_q <= transfer;
      if (transfer) begin
        out_data_q <= inData[grant*W +: W];
        out_chan_q <= grant;
        if (inMode == MODE_RR) rr_ptr_q <= ptr_next;
      end
    end
  end

`ifdef MUXN_REG_PARITY_EN
  logic par_q;

  // Parity tracks exactly what is loaded into the data register.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      par_q <= 1'b0;
    end else if (transfer) begin
      par_q <= ^inData[grant*W +: W];
    end
  end

  assign outPar = par_q;
`endif

  assign outValid = out_valid_q;
  assign outData  = out_data_q;
  assign outChan  = out_chan_q;

endmodule
